// File: rtl/mc14500_serial_rx.sv
// -----------------------------------------------------------------------------
// mc14500_serial_rx
//
// Deserializer for the MC14500 bit-banged serial port. The MC14500 program
// toggles two output-latch bits: SCLK (serial clock) and SDO (serial data).
// This block samples SDO on every SCLK rising edge and rebuilds 8-bit
// LSB-first frames:
//   sample 1      start bit (shifted out, never delivered)
//   samples 2..9  data bits, LSB first
//   sample 10     latch pulse (SDO ignored)
//   then          SCLK low with SDO high marks end of frame -> byte pushed
// Completed bytes go into a small first-word-fall-through FIFO.
//
// Parameters
//   FIFO_DEPTH   byte entries in the FIFO (power of two, 2..16)
//   TIMEOUT      clk cycles without an SCLK rise before a frame is aborted
//   SYNC_STAGES  synchronizer flops on sclk/sdo (0 = inputs already synchronous)
//
// Ports
//   clk          design clock
//   rst_n        synchronous active-low reset
//   sclk, sdo    serial clock / data from the MC14500 output latch
//   rx_data      byte at FIFO head (0x00 while the FIFO is empty)
//   rx_valid     FIFO non-empty
//   rx_ready     consumer pops the head when rx_valid & rx_ready
//   fifo_level   current entry count
//   overflow     sticky: a completed byte was dropped on a full FIFO
//   frame_err    sticky: a frame timed out mid-reception
//   clear_flags  clears overflow/frame_err; a same-cycle set wins
// -----------------------------------------------------------------------------
module mc14500_serial_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 1023,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sclk,
    input  logic                          sdo,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clear_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_STOP  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    // Next FIFO occupancy, clamped to the FIFO capacity.
    function automatic logic [LW-1:0] sat_level(input logic [LW-1:0] lvl,
                                                 input logic          inc,
                                                 input logic          dec);
        logic [LW-1:0] nxt;
        nxt = lvl;
        if (inc && !dec) begin
            nxt = (lvl == LEVEL_MAX) ? LEVEL_MAX : lvl + LW'(1);
        end else if (dec && !inc) begin
            nxt = (lvl == '0) ? '0 : lvl - LW'(1);
        end
        return nxt;
    endfunction

    // ---------------- input synchronizers ----------------
    logic sclk_s;
    logic sdo_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sclk_s = sclk;
            assign sdo_s  = sdo;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sclk_p0;
            logic [SYNC_STAGES-1:0] sdo_p0;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sclk_p0 <= '0;
                    sdo_p0  <= '0;
                end else begin
                    sclk_p0[0] <= sclk;
                    sdo_p0[0]  <= sdo;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sclk_p0[i] <= sclk_p0[i-1];
                        sdo_p0[i]  <= sdo_p0[i-1];
                    end
                end
            end

            assign sclk_s = sclk_p0[SYNC_STAGES-1];
            assign sdo_s  = sdo_p0[SYNC_STAGES-1];
        end
    endgenerate

    // ---------------- edge detect ----------------
    logic sclk_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
        end
    end

    logic rise;
    assign rise = sclk_s & ~sclk_d;

    // ---------------- frame FSM ----------------
    logic [1:0]    state;
    logic [7:0]    shift_q;
    logic [3:0]    bitcnt;
    logic [TW-1:0] tmo_cnt;

    logic tmo_hit;
    logic push_req;

    // A rise restarts the timer, so it can never coincide with a timeout.
    assign tmo_hit  = (state != ST_IDLE) && !rise && (tmo_cnt == TMO_MAX);
    // End-of-frame marker: clock parked low with data high; timeout wins.
    assign push_req = (state == ST_GAP) && !tmo_hit && !sclk_s && sdo_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shift_q <= 8'h00;
            bitcnt  <= 4'd0;
            tmo_cnt <= '0;
        end else if (state == ST_IDLE) begin
            tmo_cnt <= '0;
            if (rise) begin
                state   <= ST_SHIFT;
                bitcnt  <= 4'd1;
                shift_q <= {sdo_s, shift_q[7:1]};
            end
        end else begin
            if (rise || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (tmo_hit) begin
                state  <= ST_IDLE;
                bitcnt <= 4'd0;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (rise) begin
                            shift_q <= {sdo_s, shift_q[7:1]};
                            bitcnt  <= bitcnt + 4'd1;
                            // Ninth sample: start bit has just left shift_q[0].
                            if (bitcnt == 4'd8) begin
                                state <= ST_STOP;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (rise) begin
                            state <= ST_GAP;
                        end
                    end
                    default: begin
                        if (push_req) begin
                            state  <= ST_IDLE;
                            bitcnt <= 4'd0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;

    logic full;
    logic pop;
    logic push;
    logic ovf_set;

    assign full     = (level == LEVEL_MAX);
    assign rx_valid = (level != '0);
    assign pop      = rx_valid & rx_ready;
    // A pop on the same edge frees the slot the push needs.
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= sat_level(level, push, pop);
        end
    end

    assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_level = level;

    // ---------------- sticky flags ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow & ~clear_flags);
            frame_err <= tmo_hit | (frame_err & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_mc14500_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_mc14500_serial_rx
//
// Directed bench for mc14500_serial_rx with default parameters
// (FIFO_DEPTH=4, TIMEOUT=1023, SYNC_STAGES=2). Inputs change on the falling
// clock edge; outputs are sampled on the falling edge as well.
// -----------------------------------------------------------------------------
module tb_mc14500_serial_rx;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       sdo;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       frame_err;
    logic       clear_flags;

    int n_checks;
    int n_errors;

    mc14500_serial_rx #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (1023),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .sdo        (sdo),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clear_flags(clear_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on total run time.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] data;
        logic [2:0] exp_level;
        logic [7:0] exp_head;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // One SCLK period (20 clk): low half carries the data bit, rise samples it.
    task automatic pulse(input logic d);
        sdo  = d;
        sclk = 1'b0;
        repeat (10) @(negedge clk);
        sclk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, latch pulse; leaves sclk high.
    task automatic send_body(input logic [7:0] b);
        pulse(1'b0);
        for (int i = 0; i < 8; i++) pulse(b[i]);
        pulse(1'b0);
    endtask

    // End-of-frame marker plus settling time.
    task automatic send_frame(input logic [7:0] b);
        send_body(b);
        sclk = 1'b0;
        sdo  = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Pop exactly one entry, checking the head first.
    task automatic pop_check(input string name, input logic [7:0] exp);
        check(name, {31'd0, rx_valid}, 32'd1);
        check(name, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{8'h31, 3'd1, 8'h31, 1'b0};
        vecs[1]  = '{8'h41, 3'd2, 8'h31, 1'b0};
        vecs[2]  = '{8'h2A, 3'd3, 8'h31, 1'b0};
        vecs[3]  = '{8'h32, 3'd4, 8'h31, 1'b0};
        vecs[4]  = '{8'h45, 3'd4, 8'h31, 1'b1};
        vecs[5]  = '{8'h3D, 3'd4, 8'h31, 1'b1};
        vecs[6]  = '{8'h30, 3'd4, 8'h31, 1'b1};
        vecs[7]  = '{8'h34, 3'd4, 8'h31, 1'b1};
        vecs[8]  = '{8'h41, 3'd4, 8'h31, 1'b1};
        vecs[9]  = '{8'h43, 3'd4, 8'h31, 1'b1};
        vecs[10] = '{8'h0D, 3'd4, 8'h31, 1'b1};
        vecs[11] = '{8'h0A, 3'd4, 8'h31, 1'b1};

        rst_n       = 1'b0;
        sclk        = 1'b0;
        sdo         = 1'b1;
        rx_ready    = 1'b0;
        clear_flags = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- reset state ----
        check("reset rx_valid",   {31'd0, rx_valid},   32'd0);
        check("reset fifo_level", {29'd0, fifo_level}, 32'd0);
        check("reset rx_data",    {24'd0, rx_data},    32'd0);
        check("reset overflow",   {31'd0, overflow},   32'd0);
        check("reset frame_err",  {31'd0, frame_err},  32'd0);

        // ---- single frame 0x31, push latency ----
        send_body(8'h31);
        check("f31 valid before gap", {31'd0, rx_valid}, 32'd0);
        sclk = 1'b0;
        sdo  = 1'b1;
        repeat (2) @(negedge clk);
        check("f31 valid before push edge", {31'd0, rx_valid}, 32'd0);
        repeat (2) @(negedge clk);
        check("f31 rx_valid", {31'd0, rx_valid}, 32'd1);
        check("f31 rx_data",  {24'd0, rx_data},  32'h31);
        check("f31 frame_err", {31'd0, frame_err}, 32'd0);
        pop_check("f31 pop", 8'h31);
        check("f31 level after pop", {29'd0, fifo_level}, 32'd0);

        // ---- twelve frames, consumer always ready ----
        rx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_body(vecs[i].data);
            sclk = 1'b0;
            sdo  = 1'b1;
            repeat (3) @(negedge clk);
            check($sformatf("stream[%0d] valid", i), {31'd0, rx_valid}, 32'd1);
            check($sformatf("stream[%0d] data", i),  {24'd0, rx_data},  {24'd0, vecs[i].data});
            repeat (2) @(negedge clk);
            check($sformatf("stream[%0d] popped", i), {31'd0, rx_valid}, 32'd0);
        end
        repeat (4) @(negedge clk);
        check("stream pop-on-empty level", {29'd0, fifo_level}, 32'd0);
        check("stream overflow", {31'd0, overflow}, 32'd0);
        rx_ready = 1'b0;

        // ---- twelve frames, consumer stalled: table-driven ----
        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].data);
            check($sformatf("stall[%0d] level", i),    {29'd0, fifo_level}, {29'd0, vecs[i].exp_level});
            check($sformatf("stall[%0d] head", i),     {24'd0, rx_data},    {24'd0, vecs[i].exp_head});
            check($sformatf("stall[%0d] overflow", i), {31'd0, overflow},   {31'd0, vecs[i].exp_ovf});
        end
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("clear overflow", {31'd0, overflow}, 32'd0);
        check("clear keeps level", {29'd0, fifo_level}, 32'd4);
        pop_check("stall drain 0", 8'h31);
        pop_check("stall drain 1", 8'h41);
        pop_check("stall drain 2", 8'h2A);
        pop_check("stall drain 3", 8'h32);
        check("stall drained", {29'd0, fifo_level}, 32'd0);

        // ---- full FIFO, pop on the exact push edge of byte 5 ----
        send_frame(8'h31);
        send_frame(8'h41);
        send_frame(8'h2A);
        send_frame(8'h32);
        check("full level", {29'd0, fifo_level}, 32'd4);
        send_body(8'h45);
        sclk = 1'b0;
        sdo  = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("push+pop level",    {29'd0, fifo_level}, 32'd4);
        check("push+pop overflow", {31'd0, overflow},   32'd0);
        pop_check("push+pop drain 0", 8'h41);
        pop_check("push+pop drain 1", 8'h2A);
        pop_check("push+pop drain 2", 8'h32);
        pop_check("push+pop tail",    8'h45);
        check("push+pop drained", {29'd0, fifo_level}, 32'd0);

        // ---- timeout after 5 SCLK pulses ----
        pulse(1'b0);
        pulse(1'b1);
        pulse(1'b0);
        pulse(1'b0);
        pulse(1'b0);
        sclk = 1'b0;
        sdo  = 1'b1;
        repeat (985) @(negedge clk);
        check("timeout not yet", {31'd0, frame_err}, 32'd0);
        repeat (105) @(negedge clk);
        check("timeout frame_err", {31'd0, frame_err}, 32'd1);
        check("timeout no push",   {29'd0, fifo_level}, 32'd0);
        send_frame(8'h41);
        check("after timeout level", {29'd0, fifo_level}, 32'd1);
        pop_check("after timeout 0x41", 8'h41);
        check("frame_err sticky", {31'd0, frame_err}, 32'd1);

        // ---- reset mid-frame with two bytes queued ----
        send_frame(8'h31);
        send_frame(8'h41);
        check("pre-reset level", {29'd0, fifo_level}, 32'd2);
        for (int i = 0; i < 6; i++) pulse(i[0]);
        sclk  = 1'b0;
        sdo   = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid reset rx_valid",   {31'd0, rx_valid},   32'd0);
        check("mid reset fifo_level", {29'd0, fifo_level}, 32'd0);
        check("mid reset overflow",   {31'd0, overflow},   32'd0);
        check("mid reset frame_err",  {31'd0, frame_err},  32'd0);
        check("mid reset rx_data",    {24'd0, rx_data},    32'd0);
        send_frame(8'h0A);
        check("post reset level", {29'd0, fifo_level}, 32'd1);
        pop_check("post reset 0x0A", 8'h0A);
        check("post reset frame_err", {31'd0, frame_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
